// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side deserializer for the PHY lane.
// Hunts for byte alignment on the COM symbol and declares lock after
// COM_COUNT COMs that arrive on consecutive byte boundaries. Once locked,
// it presents each recovered data byte and flags idle COM bytes as not valid.
//
// Ports:
//   clk_32f     in   bit-rate clock, rising edge
//   reset       in   synchronous, active-high
//   data_in     in   serial bit, MSB of each byte first
//   data_out    out  [7:0] last recovered non-COM byte
//   valid_out   out  high while data_out holds a fresh data byte
//   byte_strobe out  one-cycle pulse on each byte boundary while locked
//   active      out  high while locked
module serial_paralelo #(
  parameter logic [7:0]  COM_SYM   = 8'hBC,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    LOCKED
  } state_t;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_t     state, state_nxt;
  logic [7:0] sh;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       strobe_nxt;
  logic       active_nxt;
  logic       is_com;
  logic       boundary;

  // Detection always works on the registered shift value, so a byte whose
  // last bit lands on edge N is acted on at edge N+1.
  assign is_com   = (sh == COM_SYM);
  assign boundary = (bit_cnt == 3'd0) && (state != HUNT);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= HUNT;
      sh          <= '0;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      sh          <= {sh[6:0], data_in};
      bit_cnt     <= bit_cnt_nxt;
      com_cnt     <= com_cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
      active      <= active_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;
    strobe_nxt  = 1'b0;
    active_nxt  = active;

    case (state)
      HUNT: begin
        // Any bit phase is accepted here; the COM just seen counts as the first.
        if (is_com) begin
          state_nxt   = ALIGN;
          bit_cnt_nxt = 3'd1;
          com_cnt_nxt = 4'd1;
        end
      end

      ALIGN: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_nxt = com_cnt + 4'd1;
            // bit_cnt_nxt is already 1 here, which starts the first locked byte.
            if ((com_cnt + 4'd1) == COM_TARGET) begin
              state_nxt  = LOCKED;
              active_nxt = 1'b1;
            end
          end else begin
            state_nxt   = HUNT;
            com_cnt_nxt = '0;
            bit_cnt_nxt = '0;
          end
        end
      end

      LOCKED: begin
        // No loss-of-lock detection: only reset leaves this state.
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_nxt = 1'b1;
          if (is_com) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt  = sh;
            valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: lock timing, idle COM handling,
// false-start rejection, arbitrary power-up bit phase, mid-stream reset and
// a COM_COUNT=2 instance.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  logic [7:0] data_out2;
  logic       valid_out2;
  logic       byte_strobe2;
  logic       active2;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  int cyc         = 0;
  int strobe_cnt  = 0;
  int strobe_at   = 0;
  int strobe_gap  = 0;

  serial_paralelo #(
    .COM_SYM  (8'hBC),
    .COM_COUNT(4)
  ) u_dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  serial_paralelo #(
    .COM_SYM  (8'hBC),
    .COM_COUNT(2)
  ) u_dut2 (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out2),
    .valid_out  (valid_out2),
    .byte_strobe(byte_strobe2),
    .active     (active2)
  );

  always #5 clk_32f = ~clk_32f;

  always @(posedge clk_32f) cyc <= cyc + 1;

  always @(negedge clk_32f) begin
    if (byte_strobe) begin
      strobe_gap = cyc - strobe_at;
      strobe_at  = cyc;
      strobe_cnt = strobe_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Sends the low n bits of v, most significant first; returns #1 after the
  // edge that captured the last bit.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = v[i];
      @(posedge clk_32f);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({8'h00, b}, 8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    send_bits(16'h0000, 2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL reset_data: got %h want %h", data_out, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want %b", valid_out, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (byte_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want %b", byte_strobe, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (active !== 1'b0) $display("FAIL reset_active: got %b want %b", active, 1'b0);
    else pass_cnt++;
  endtask

  // Leaves the DUT locked with 0x1C as the byte awaiting its boundary.
  task automatic test_lock();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    send_bits(16'h1234, 16);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    total_cnt++;
    if (active !== 1'b0) $display("FAIL lock_before_boundary: active got %b want %b", active, 1'b0);
    else pass_cnt++;
    send_bits(16'h0000, 1);          // first bit of 0x3C; edge of 4th COM boundary
    total_cnt++;
    if (active !== 1'b1) $display("FAIL lock_at_boundary: active got %b want %b", active, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (valid_out !== 1'b0 || byte_strobe !== 1'b0)
      $display("FAIL lock_com_not_data: valid/strobe got %b/%b want 0/0", valid_out, byte_strobe);
    else pass_cnt++;
    send_bits(16'h003C, 7);
    total_cnt++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || strobe_cnt != s0)
      $display("FAIL lock_no_early_data: data/valid/strobes got %h/%b/%0d want 00/0/0",
               data_out, valid_out, strobe_cnt - s0);
    else pass_cnt++;
    send_byte(8'h1C);
    total_cnt++;
    if (data_out !== 8'h3C || valid_out !== 1'b1)
      $display("FAIL lock_first_byte: data/valid got %h/%b want 3c/1", data_out, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_idle();
    logic [7:0] tx    [5] = '{8'hA5, 8'hBC, 8'hBC, 8'h7E, 8'h00};
    logic [7:0] exp_d [5] = '{8'h1C, 8'hA5, 8'hA5, 8'hA5, 8'h7E};
    logic       exp_v [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int s0;
    for (int i = 0; i < 5; i++) begin
      s0 = strobe_cnt;
      send_byte(tx[i]);
      total_cnt++;
      if (data_out !== exp_d[i] || valid_out !== exp_v[i])
        $display("FAIL idle_byte%0d: data/valid got %h/%b want %h/%b",
                 i, data_out, valid_out, exp_d[i], exp_v[i]);
      else pass_cnt++;
      total_cnt++;
      if (strobe_cnt - s0 != 1 || strobe_gap != 8)
        $display("FAIL idle_strobe%0d: pulses/gap got %0d/%0d want 1/8",
                 i, strobe_cnt - s0, strobe_gap);
      else pass_cnt++;
    end
  endtask

  task automatic test_false_start();
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    send_bits(16'h0001, 1);          // 0x55 boundary edge; first bit of COM
    total_cnt++;
    if (active !== 1'b0) $display("FAIL false_start_active: got %b want %b", active, 1'b0);
    else pass_cnt++;
    send_bits(16'h003C, 7);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_byte(8'h66);
    total_cnt++;
    if (active !== 1'b1) $display("FAIL false_start_relock: active got %b want %b", active, 1'b1);
    else pass_cnt++;
    send_byte(8'h00);
    total_cnt++;
    if (data_out !== 8'h66 || valid_out !== 1'b1)
      $display("FAIL false_start_data: data/valid got %h/%b want 66/1", data_out, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_bit_slip();
    do_reset();
    send_bits(16'h0002, 3);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    total_cnt++;
    if (active !== 1'b0) $display("FAIL slip_early_lock: active got %b want %b", active, 1'b0);
    else pass_cnt++;
    send_byte(8'hBC);
    send_byte(8'h81);
    send_byte(8'h00);
    total_cnt++;
    if (data_out !== 8'h81 || valid_out !== 1'b1 || active !== 1'b1)
      $display("FAIL slip_data: data/valid/active got %h/%b/%b want 81/1/1",
               data_out, valid_out, active);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send_bits(16'h0007, 3);          // partial byte while locked
    reset = 1'b1;
    send_bits(16'h0000, 1);
    reset = 1'b0;
    total_cnt++;
    if (active !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00 || byte_strobe !== 1'b0)
      $display("FAIL mid_reset: active/valid/data/strobe got %b/%b/%h/%b want 0/0/00/0",
               active, valid_out, data_out, byte_strobe);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    total_cnt++;
    if (active !== 1'b0) $display("FAIL mid_reset_early_lock: active got %b want %b", active, 1'b0);
    else pass_cnt++;
    send_byte(8'hBC);
    send_byte(8'h5A);
    send_byte(8'h00);
    total_cnt++;
    if (data_out !== 8'h5A || valid_out !== 1'b1 || active !== 1'b1)
      $display("FAIL mid_reset_relock: data/valid/active got %h/%b/%b want 5a/1/1",
               data_out, valid_out, active);
    else pass_cnt++;
  endtask

  task automatic test_com_count2();
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    total_cnt++;
    if (active2 !== 1'b0) $display("FAIL cc2_before_lock: active got %b want %b", active2, 1'b0);
    else pass_cnt++;
    send_byte(8'h42);
    total_cnt++;
    if (active2 !== 1'b1 || valid_out2 !== 1'b0)
      $display("FAIL cc2_lock: active/valid got %b/%b want 1/0", active2, valid_out2);
    else pass_cnt++;
    total_cnt++;
    if (active !== 1'b0) $display("FAIL cc4_not_locked: active got %b want %b", active, 1'b0);
    else pass_cnt++;
    send_byte(8'h00);
    total_cnt++;
    if (data_out2 !== 8'h42 || valid_out2 !== 1'b1)
      $display("FAIL cc2_data: data/valid got %h/%b want 42/1", data_out2, valid_out2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_idle();
    test_false_start();
    test_bit_slip();
    test_reset_mid();
    test_com_count2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
Receive-side deserializer for the PHY lane. It takes the serial bitstream, MSB first, produced by the lane serializer and finds byte alignment by hunting for the COM symbol 0xBC. It declares lock after a configurable run of aligned COMs, then presents recovered bytes with a valid flag. Idle COM bytes are reported as not-valid, mirroring the transmit side, which sends 0xBC whenever its valid_in is low.

Parameters:
COM_SYM, 8'hBC, symbol used for alignment and idle fill
COM_COUNT, 4, consecutive byte-aligned COMs required to lock (legal range 2..15)

Ports:
clk_32f  input  1  bit-rate clock; everything is registered on its rising edge
reset  input  1  synchronous, active-high reset
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last recovered non-COM byte
valid_out  output  1  high while data_out holds a fresh data byte; updated once per byte period
byte_strobe  output  1  one-cycle pulse on every byte boundary while LOCKED
active  output  1  high while in LOCKED state

Behaviour:
- Shift register: sh[7:0] <= {sh[6:0], data_in} every cycle, including during HUNT. Reset clears sh to 0.
- All detection and compare logic uses the registered sh value.
- bit_cnt (3-bit) and com_cnt (4-bit) are internal counters; both reset to 0.
- A byte boundary is a cycle with bit_cnt==0 while in ALIGN or LOCKED.
- States: HUNT (reset state), ALIGN, LOCKED.
- HUNT:
  - sh is compared every cycle.
  - On sh==COM_SYM: go to ALIGN, bit_cnt<=1, com_cnt<=1.
- ALIGN:
  - bit_cnt increments every cycle and wraps 7->0.
  - At a boundary with sh==COM_SYM: com_cnt<=com_cnt+1. If com_cnt+1==COM_COUNT, go to LOCKED and set bit_cnt<=1.
  - At a boundary with sh!=COM_SYM: go to HUNT, com_cnt<=0.
  - Non-boundary cycles ignore sh contents.
- LOCKED:
  - bit_cnt keeps wrapping. The state is held until reset; there is no loss-of-lock detection in this revision.
  - At a boundary, byte_strobe<=1 for exactly one cycle.
  - If sh==COM_SYM: valid_out<=0 and data_out holds its previous value.
  - Otherwise: data_out<=sh and valid_out<=1.
  - valid_out and data_out are stable for 8 cycles between boundaries.
- Latency: the last bit of a byte is presented on data_in at edge N, giving sh==byte after edge N. data_out, valid_out and byte_strobe reflect that byte after edge N+1.
- active<=1 on the same edge that enters LOCKED and is 0 in HUNT/ALIGN.
- valid_out, byte_strobe and data_out stay 0 outside LOCKED.
- The first boundary after lock is 8 cycles after the locking COM boundary. The COM itself is never reported as data.
- Reset values: data_out=8'h00, valid_out=0, byte_strobe=0, active=0, state=HUNT.
- Reset asserted mid-byte or while LOCKED takes effect on the next edge: all outputs return to reset values. After deassertion the block re-hunts from scratch and the partial byte is discarded.
- Misaligned COM patterns that form across a byte boundary (e.g. data 0x5E,0x00 yields 0xBC one bit later) are only acted on in HUNT. ALIGN rejects them unless they repeat on 8-bit spacing COM_COUNT times.

Test Plan:
- Lock: 16 random bits, then 4x 0xBC, then 0x3C, 0x1C1 MSB first → active rises exactly at the 4th COM boundary. 8 cycles after the 4th COM, data_out=8'h3C with valid_out=1. The next boundary gives data_out=8'h1C.
- Idle: after lock send 0xA5, 0xBC, 0xBC, 0x7E → valid_out pattern at boundaries is 1,0,0,1. data_out shows 0xA5 through both COM periods, then 0x7E. byte_strobe pulses 4 times, 8 cycles apart.
- False start: 0xBC, 0xBC, 0x55 (only 2 COMs), then 4x 0xBC → returns to HUNT at the 0x55 boundary with active=0. It then locks on the subsequent 4-COM run.
- Bit-slip entry: 3 leading junk bits, then 4x 0xBC, 0x81 → lock is achieved on the offset stream. data_out=8'h81 proves alignment is independent of the power-up phase.
- Reset mid-operation: assert reset for 1 cycle in the middle of a locked data byte → next edge shows active=0, valid_out=0, data_out=0. After 4 fresh COMs the block relocks and decodes the following byte correctly.
- Parameter: COM_COUNT=2 with 2x 0xBC, 0x42 → active high after the 2nd COM, then data_out=8'h42 with valid_out=1.
